// File: rtl/exception_unit_pkg.sv
// Shared types for the exception unit: ExcCode values, per-instruction tag and FSM states.
package exc_pkg;

  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;
  localparam int          FLUSH_CYCLES = 2;
  localparam int          CNT_W        = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [4:0] {
    INT  = 5'd0,
    ADEL = 5'd4,
    ADES = 5'd5,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    exc_code_e   code;
    logic [31:0] badva;
    logic        eret;
  } exc_tag_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

endpackage

// File: rtl/exception_unit_if.sv
// Stage exception reports in, cp0 exception-entry / fetch-redirect controls out.
interface exception_unit_if;
  logic        stall;
  logic        valid_d;
  logic [31:0] pc_d;
  logic        bd_d;
  logic        f_adel;
  logic        d_ri;
  logic        d_syscall;
  logic        d_break;
  logic        d_eret;
  logic        e_ovf;
  logic        m_adel;
  logic        m_ades;
  logic [31:0] m_va;
  logic        int_counter;
  logic [31:0] epc_q;

  logic        e_enter;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [31:0] bad_va;
  logic        delay_slot;
  logic        eret;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output stall, valid_d, pc_d, bd_d, f_adel, d_ri, d_syscall, d_break, d_eret,
           e_ovf, m_adel, m_ades, m_va, int_counter, epc_q,
    input  e_enter, cause, epc, bad_va, delay_slot, eret, flush, redirect,
           redirect_pc, busy
  );

  modport slave (
    input  stall, valid_d, pc_d, bd_d, f_adel, d_ri, d_syscall, d_break, d_eret,
           e_ovf, m_adel, m_ades, m_va, int_counter, epc_q,
    output e_enter, cause, epc, bad_va, delay_slot, eret, flush, redirect,
           redirect_pc, busy
  );
endinterface

// File: rtl/exception_unit_tag_reg.sv
// One pipeline exception-tag slot: 1-cycle register, holds on stall, flush clears it
// (flush wins over stall).
module exc_tag_reg
  import exc_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     stall,
  input  logic     flush,
  input  exc_tag_t d,
  output exc_tag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Tags instructions D->E->M, commits one exception/ERET per cycle at M/W; strobes one cycle
// after commit. Stall holds tags and defers commit; the flush window overrides stall.
module exception_unit
  import exc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  exception_unit_if.slave  eu
);

  exc_tag_t         d_in, d_q, e_in, e_q, m_in, m_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle, take_int, take_exc, take_eret, commit, clear;
  logic [4:0]       cause_n;
  logic [31:0]      epc_n, bad_va_n, rpc_n;
  logic             ds_n;

  // Decode priority: fetch address error first, then RI, SYSCALL, BREAK.
  always_comb begin
    d_in       = '0;
    d_in.valid = eu.valid_d;
    d_in.pc    = eu.pc_d;
    d_in.bd    = eu.bd_d;
    d_in.eret  = eu.valid_d & eu.d_eret;
    if (eu.valid_d) begin
      if (eu.f_adel) begin
        d_in.exc   = 1'b1;
        d_in.code  = ADEL;
        d_in.badva = eu.pc_d;
      end else if (eu.d_ri) begin
        d_in.exc  = 1'b1;
        d_in.code = RI;
      end else if (eu.d_syscall) begin
        d_in.exc  = 1'b1;
        d_in.code = SYS;
      end else if (eu.d_break) begin
        d_in.exc  = 1'b1;
        d_in.code = BP;
      end
    end
  end

  // Later stages only report if no earlier stage already did.
  always_comb begin
    e_in = d_q;
    if (d_q.valid && !d_q.exc && eu.e_ovf) begin
      e_in.exc  = 1'b1;
      e_in.code = OV;
    end
    m_in = e_q;
    if (e_q.valid && !e_q.exc && (eu.m_adel || eu.m_ades)) begin
      m_in.exc   = 1'b1;
      m_in.badva = eu.m_va;
      if (eu.m_adel) m_in.code = ADEL;
      else           m_in.code = ADES;
    end
  end

  assign idle      = (state_q == IDLE);
  assign take_int  = m_q.valid & eu.int_counter;
  assign take_exc  = take_int | (m_q.valid & m_q.exc);
  assign take_eret = m_q.valid & m_q.eret & ~take_exc;
  assign commit    = idle & ~eu.stall & (take_exc | take_eret);
  // Clearing on the commit edge itself drops younger instructions immediately.
  assign clear     = commit | ~idle;

  exc_tag_reg u_tag_d (.clk(clk), .rst_n(rst_n), .stall(eu.stall), .flush(clear), .d(d_in), .q(d_q));
  exc_tag_reg u_tag_e (.clk(clk), .rst_n(rst_n), .stall(eu.stall), .flush(clear), .d(e_in), .q(e_q));
  exc_tag_reg u_tag_m (.clk(clk), .rst_n(rst_n), .stall(eu.stall), .flush(clear), .d(m_in), .q(m_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cause_n  = '0;
    epc_n    = '0;
    bad_va_n = '0;
    ds_n     = 1'b0;
    rpc_n    = '0;
    if (commit && take_exc) begin
      cause_n = m_q.code;
      if (take_int) cause_n = INT;
      epc_n   = m_q.bd ? (m_q.pc - 32'd4) : m_q.pc;
      ds_n    = m_q.bd;
      rpc_n   = EXC_VECTOR;
      if (!take_int && (m_q.code == ADEL || m_q.code == ADES)) bad_va_n = m_q.badva;
    end else if (commit) begin
      rpc_n = eu.epc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      eu.e_enter     <= 1'b0;
      eu.eret        <= 1'b0;
      eu.redirect    <= 1'b0;
      eu.cause       <= '0;
      eu.epc         <= '0;
      eu.bad_va      <= '0;
      eu.delay_slot  <= 1'b0;
      eu.redirect_pc <= '0;
      eu.flush       <= 1'b0;
      eu.busy        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      eu.e_enter     <= commit & take_exc;
      eu.eret        <= commit & take_eret;
      eu.redirect    <= commit;
      eu.cause       <= cause_n;
      eu.epc         <= epc_n;
      eu.bad_va      <= bad_va_n;
      eu.delay_slot  <= ds_n;
      eu.redirect_pc <= rpc_n;
      eu.flush       <= (state_d == FLUSH);
      eu.busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed plus random stimulus against an instruction-level model of the exception unit.
module tb_exception_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exception_unit_if bus ();

  exception_unit dut (.clk(clk), .rst_n(rst_n), .eu(bus));

  // Model: each in-flight instruction keeps its raw reports; resolution happens at commit.
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          bd, fadel, ri, sys, brk, eret, ovf, adel, ades;
    logic [31:0] va;
  } ins_t;

  ins_t        pipe[3];
  int          flush_left;
  int          checks, passes;
  logic        exp_e_enter, exp_eret, exp_redirect, exp_ds, exp_flush, exp_busy;
  logic [4:0]  exp_cause;
  logic [31:0] exp_epc, exp_bva, exp_rpc;

  function automatic void resolve(input ins_t r, output bit exc, output logic [4:0] code,
                                  output logic [31:0] bva);
    exc = 1'b1;
    bva = '0;
    code = '0;
    if      (r.fadel) begin code = 5'd4; bva = r.pc; end
    else if (r.ri)    code = 5'd10;
    else if (r.sys)   code = 5'd8;
    else if (r.brk)   code = 5'd9;
    else if (r.ovf)   code = 5'd12;
    else if (r.adel)  begin code = 5'd4; bva = r.va; end
    else if (r.ades)  begin code = 5'd5; bva = r.va; end
    else              exc = 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: '0};
    flush_left = 0;
    {exp_e_enter, exp_eret, exp_redirect, exp_ds, exp_flush, exp_busy} = '0;
    exp_cause = '0; exp_epc = '0; exp_bva = '0; exp_rpc = '0;
  endtask

  task automatic model_edge();
    ins_t        h;
    bit          exc, t_int, t_exc, t_eret, commit;
    logic [4:0]  code;
    logic [31:0] bva;
    h = pipe[2];
    resolve(h, exc, code, bva);
    t_int  = h.valid && bus.int_counter;
    t_exc  = t_int || (h.valid && exc);
    t_eret = !t_exc && h.valid && h.eret;
    commit = (flush_left == 0) && !bus.stall && (t_exc || t_eret);
    {exp_e_enter, exp_eret, exp_redirect, exp_ds} = '0;
    exp_cause = '0; exp_epc = '0; exp_bva = '0; exp_rpc = '0;
    if (commit && t_exc) begin
      exp_e_enter  = 1'b1;
      exp_redirect = 1'b1;
      exp_cause    = t_int ? 5'd0 : code;
      exp_epc      = h.bd ? h.pc - 32'd4 : h.pc;
      exp_ds       = h.bd;
      exp_bva      = (exp_cause == 5'd4 || exp_cause == 5'd5) ? bva : 32'd0;
      exp_rpc      = 32'h0000_0180;
    end else if (commit) begin
      exp_eret     = 1'b1;
      exp_redirect = 1'b1;
      exp_rpc      = bus.epc_q;
    end
    if (commit || flush_left > 0) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{default: '0};
    end else if (!bus.stall) begin
      pipe[2] = pipe[1];
      if (pipe[2].valid) begin
        pipe[2].adel = bus.m_adel;
        pipe[2].ades = bus.m_ades;
        pipe[2].va   = bus.m_va;
      end
      pipe[1] = pipe[0];
      if (pipe[1].valid) pipe[1].ovf = bus.e_ovf;
      pipe[0] = '{default: '0};
      if (bus.valid_d) begin
        pipe[0].valid = 1'b1;
        pipe[0].pc    = bus.pc_d;
        pipe[0].bd    = bus.bd_d;
        pipe[0].fadel = bus.f_adel;
        pipe[0].ri    = bus.d_ri;
        pipe[0].sys   = bus.d_syscall;
        pipe[0].brk   = bus.d_break;
        pipe[0].eret  = bus.d_eret;
      end
    end
    if (commit) flush_left = 2;
    else if (flush_left > 0) flush_left--;
    exp_flush = (flush_left > 0);
    exp_busy  = (flush_left > 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic compare_all();
    check("e_enter",     32'(bus.e_enter),     32'(exp_e_enter));
    check("eret",        32'(bus.eret),        32'(exp_eret));
    check("redirect",    32'(bus.redirect),    32'(exp_redirect));
    check("cause",       32'(bus.cause),       32'(exp_cause));
    check("epc",         bus.epc,              exp_epc);
    check("bad_va",      bus.bad_va,           exp_bva);
    check("delay_slot",  32'(bus.delay_slot),  32'(exp_ds));
    check("redirect_pc", bus.redirect_pc,      exp_rpc);
    check("flush",       32'(bus.flush),       32'(exp_flush));
    check("busy",        32'(bus.busy),        32'(exp_busy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    bus.stall = 0; bus.valid_d = 0; bus.pc_d = '0; bus.bd_d = 0; bus.f_adel = 0;
    bus.d_ri = 0; bus.d_syscall = 0; bus.d_break = 0; bus.d_eret = 0; bus.e_ovf = 0;
    bus.m_adel = 0; bus.m_ades = 0; bus.m_va = '0; bus.int_counter = 0;
  endtask

  task automatic drive_d(input logic [31:0] pc, input bit bd, input bit fadel, input bit ri,
                         input bit sys, input bit brk, input bit er);
    bus.valid_d = 1; bus.pc_d = pc; bus.bd_d = bd; bus.f_adel = fadel;
    bus.d_ri = ri; bus.d_syscall = sys; bus.d_break = brk; bus.d_eret = er;
  endtask

  task automatic wait_strobe(input int max);
    for (int i = 0; i < max; i++) begin
      if (bus.e_enter || bus.eret) break;
      step();
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    rst_n = 1'b0;
    bus.epc_q = '0;
    clear_in();
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // SYSCALL outside a delay slot
    drive_d(32'h100, 0, 0, 0, 1, 0, 0); step(); clear_in(); wait_strobe(8);
    check("sys_enter", 32'(bus.e_enter), 32'd1);
    check("sys_cause", 32'(bus.cause), 32'd8);
    check("sys_epc", bus.epc, 32'h100);
    check("sys_badva", bus.bad_va, 32'd0);
    check("sys_rpc", bus.redirect_pc, 32'h180);
    check("sys_flush1", 32'(bus.flush), 32'd1);
    step(); check("sys_flush2", 32'(bus.flush), 32'd1);
    step(); check("sys_flush_end", 32'(bus.flush), 32'd0);

    // Delay-slot load with data address error
    drive_d(32'h204, 1, 0, 0, 0, 0, 0); step(); clear_in(); step();
    bus.m_adel = 1; bus.m_va = 32'h1003; step(); clear_in(); wait_strobe(6);
    check("adel_cause", 32'(bus.cause), 32'd4);
    check("adel_epc", bus.epc, 32'h200);
    check("adel_ds", 32'(bus.delay_slot), 32'd1);
    check("adel_badva", bus.bad_va, 32'h1003);
    repeat (3) step();

    // RI and overflow on the same instruction: RI wins
    drive_d(32'h300, 0, 0, 1, 0, 0, 0); step(); clear_in();
    bus.e_ovf = 1; step(); clear_in(); wait_strobe(6);
    check("ri_cause", 32'(bus.cause), 32'd10);
    repeat (3) step();

    // Interrupt while an overflowing ADD sits at the commit point
    drive_d(32'h40, 0, 0, 0, 0, 0, 0); step(); clear_in();
    bus.e_ovf = 1; step(); clear_in(); step();
    bus.int_counter = 1; step(); clear_in();
    check("int_enter", 32'(bus.e_enter), 32'd1);
    check("int_cause", 32'(bus.cause), 32'd0);
    check("int_epc", bus.epc, 32'h40);
    repeat (3) step();

    // ERET
    bus.epc_q = 32'h3000;
    drive_d(32'h500, 0, 0, 0, 0, 0, 1); step(); clear_in(); wait_strobe(6);
    check("eret_pulse", 32'(bus.eret), 32'd1);
    check("eret_rpc", bus.redirect_pc, 32'h3000);
    check("eret_no_enter", 32'(bus.e_enter), 32'd0);
    repeat (3) step();

    // STALL holds a committed-ready SYSCALL
    drive_d(32'h600, 0, 0, 0, 1, 0, 0); step(); clear_in(); step(); step();
    bus.stall = 1;
    repeat (3) begin step(); check("stall_hold", 32'(bus.e_enter), 32'd0); end
    bus.stall = 0; step();
    check("stall_release", 32'(bus.e_enter), 32'd1);
    check("stall_cause", 32'(bus.cause), 32'd8);
    check("stall_epc", bus.epc, 32'h600);
    repeat (3) step();

    // Reset in the middle of the flush window
    drive_d(32'h700, 0, 0, 0, 1, 0, 0); step(); clear_in(); wait_strobe(6);
    check("prerst_flush", 32'(bus.flush), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    repeat (400) begin
      bus.stall       = ($urandom_range(0, 5) == 0);
      bus.valid_d     = ($urandom_range(0, 3) != 0);
      bus.pc_d        = $urandom() & 32'hFFFF_FFFC;
      bus.bd_d        = ($urandom_range(0, 3) == 0);
      bus.f_adel      = ($urandom_range(0, 15) == 0);
      bus.d_ri        = ($urandom_range(0, 15) == 0);
      bus.d_syscall   = ($urandom_range(0, 15) == 0);
      bus.d_break     = ($urandom_range(0, 15) == 0);
      bus.d_eret      = ($urandom_range(0, 9) == 0);
      bus.e_ovf       = ($urandom_range(0, 9) == 0);
      bus.m_adel      = ($urandom_range(0, 11) == 0);
      bus.m_ades      = ($urandom_range(0, 11) == 0);
      bus.m_va        = $urandom();
      bus.int_counter = ($urandom_range(0, 19) == 0);
      bus.epc_q       = $urandom();
      step();
    end
    clear_in();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Exception-side counterpart of coprocessor 0. It collects exception reports from the fetch, decode, execute and memory stages, tags each instruction as it moves down the pipeline, and commits at most one event per cycle at the M/W boundary. On commit it drives the if_except inputs of coprocessor 0 (E_ENTER, CAUSE, EPC, BAD_VA, DELAY_SLOT, ERET), flushes the pipeline and redirects fetch to the exception vector or to EPC.

## Interface
- EXC_VECTOR, 32'h0000_0180, general exception vector.
- FLUSH_CYCLES, 2, cycles FLUSH stays high after a commit (≥1).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- STALL  in  1  pipeline hold; tag registers hold, no commit.
- VALID_D  in  1  D stage holds a real instruction (not a bubble).
- PC_D  in  32  PC of the D instruction.
- BD_D  in  1  D instruction sits in a branch delay slot.
- F_ADEL  in  1  fetch address error for the D instruction.
- D_RI, D_SYSCALL, D_BREAK, D_ERET  in  1 each  decode results for D.
- E_OVF  in  1  arithmetic overflow in E.
- M_ADEL, M_ADES  in  1 each  data address error in M.
- M_VA  in  32  data virtual address in M.
- INT_COUNTER  in  1  qualified interrupt request from cp0.
- EPC_Q  in  32  current EPC from cp0.
- E_ENTER  out  1  one-cycle exception-entry strobe to cp0.
- CAUSE  out  5  ExcCode.
- EPC  out  32  restart PC.
- BAD_VA  out  32  faulting address.
- DELAY_SLOT  out  1  BD bit.
- ERET  out  1  one-cycle return strobe to cp0.
- FLUSH  out  1  kill D/E/M and suppress the W write.
- REDIRECT  out  1  one-cycle fetch redirect.
- REDIRECT_PC  out  32  redirect target.
- BUSY  out  1  FSM not in IDLE.

## Operation
- Every output resets to 0.
- Tag format, one per D/E/M slot: {valid, pc, bd, exc, code[4:0], badva, eret}.
- Captured in D from VALID_D/PC_D/BD_D. First exception in the order F_ADEL(4), RI(10), SYSCALL(8), BREAK(9) sets exc/code. For F_ADEL, badva=PC_D.
- In E, E_OVF sets code 12 only if exc is not already set.
- In M, M_ADEL (4) or M_ADES (5) sets the code with badva=M_VA, only if exc is not already set. The earliest exception always wins.
- Commit evaluates the M tag when STALL=0 and the FSM is IDLE. Priority:
  - INT_COUNTER with M valid: code 0.
  - Else exc set: that code.
  - Else eret set: return.
  - Else nothing.
- On exception commit:
  - EPC = bd ? pc−4 : pc; DELAY_SLOT = bd.
  - BAD_VA = badva for codes 4 and 5, otherwise 0.
  - REDIRECT_PC = EXC_VECTOR.
- On ERET commit: ERET pulses and REDIRECT_PC = EPC_Q. An exception on the same instruction takes precedence over ERET.
- FSM states:
  - IDLE → FLUSH on commit.
  - FLUSH: counts FLUSH_CYCLES. All tag valids are cleared and stage inputs are ignored. Returns to IDLE when the count expires.
- An exception in M discards any simultaneous younger reports.

## Timing
- Commit decided in cycle t. In cycle t+1, E_ENTER or ERET, REDIRECT, CAUSE, EPC, BAD_VA and DELAY_SLOT are valid for exactly one cycle; all outputs are registered.
- FLUSH is high in t+1 … t+FLUSH_CYCLES and BUSY matches it. Commit is possible again from t+FLUSH_CYCLES+1.
- Data outputs return to 0 when their strobe is low.
- With STALL=1, tags hold and commit is deferred; a pending interrupt waits.
- FLUSH overrides STALL.
- Reset asserted mid-FLUSH returns the FSM to IDLE immediately, clears all tags and drops all outputs asynchronously.

## Structure
- Package exc_pkg holds:
  - ExcCode enum: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12.
  - exc_tag_t struct.
  - FSM state enum {IDLE, FLUSH}.
- Sub-module exc_tag_reg: one tag slot with async active-low reset, hold on STALL, clear on FLUSH. Instantiated three times (D, E, M).

## Test plan
- SYSCALL at PC 0x100 (not in a delay slot) → reaches M → next cycle:
  - E_ENTER=1, CAUSE=8, EPC=0x100, BAD_VA=0.
  - REDIRECT_PC=0x180, FLUSH high 2 cycles.
- Branch delay-slot load at PC 0x204 with M_VA=0x1003 and M_ADEL:
  - CAUSE=4, EPC=0x200, DELAY_SLOT=1, BAD_VA=0x1003.
- Instruction with both RI and E_OVF → CAUSE=10 only; the overflow is ignored.
- INT_COUNTER=1 while M holds an overflowing ADD at 0x40 → CAUSE=0, EPC=0x40.
- ERET committed with EPC_Q=0x3000 → ERET pulse, REDIRECT_PC=0x3000, E_ENTER=0.
- Corner cases:
  - STALL held 3 cycles with a SYSCALL in M: no strobe until STALL drops.
  - RESET_N low mid-FLUSH: all outputs 0 and BUSY=0 at once.
